// File: rtl/uart_receiver_pkg.sv
// Shared UART constants and receiver state encoding, used by the receiver, transmitter and baud divider.
package uart_receiver_pkg;

    localparam int DEF_BAUD_RATE  = 115200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_START     = 3'b001,
        ST_DATA      = 3'b010,
        ST_STOP      = 3'b011,
        ST_WAIT_IDLE = 3'b100
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial input side (tick, line) and parallel byte output side of the UART receiver.
interface uart_receiver_if #(parameter int DATA_BITS = uart_receiver_pkg::DEF_DATA_BITS);

    logic                 sample_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output sample_tick, rx_in,
        input  data_out, data_valid, frame_err, rx_busy
    );

    modport slave (
        input  sample_tick, rx_in,
        output data_out, data_valid, frame_err, rx_busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk_in cycles latency, no backpressure.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop recovery, byte + one-cycle valid/error pulse.
// Pulses follow the stop-sample tick by one clk_in cycle; no downstream backpressure (new byte overwrites).
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic            clk_in,
    input  logic            reset,
    uart_receiver_if.slave  rx_if
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 tick;
    logic [1:0]           sync_age_q;
    logic                 sync_primed;

    rx_state_t            state_q,      state_d;
    logic [TW-1:0]        tick_cnt_q,   tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 armed_q,      armed_d;
    logic                 rx_busy_q;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (rx_if.rx_in),
        .q      (rx_sync)
    );

    assign tick        = rx_if.sample_tick;
    // The synchronizer output is its reset value, not the line, for two cycles after reset.
    assign sync_primed = sync_age_q[1];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            armed_q      <= 1'b0;
            rx_busy_q    <= 1'b0;
            sync_age_q   <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            armed_q      <= armed_d;
            rx_busy_q    <= (state_d != ST_IDLE);
            sync_age_q   <= {sync_age_q[0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE:
                    if (armed_q && !rx_sync) state_d = ST_START;
                ST_START:
                    if (tick_cnt_q == TICK_HALF) state_d = rx_sync ? ST_IDLE : ST_DATA;
                ST_DATA:
                    if (tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                ST_STOP:
                    if (tick_cnt_q == TICK_LAST) state_d = rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE:
                    if (rx_sync) state_d = ST_IDLE;
                default:
                    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        // Only a line seen high while idle may start a frame, so a reset mid-frame cannot resync on data bits.
        armed_d      = armed_q | (tick && state_q == ST_IDLE && rx_sync && sync_primed);

        if (tick) begin
            if (state_d != state_q)
                tick_cnt_d = '0;
            else if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)
                tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;

            unique case (state_q)
                ST_START:
                    if (tick_cnt_q == TICK_HALF && !rx_sync) bit_cnt_d = '0;
                ST_DATA:
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                ST_STOP:
                    if (tick_cnt_q == TICK_LAST) begin
                        data_out_d   = shift_q;
                        data_valid_d = rx_sync;
                        frame_err_d  = !rx_sync;
                    end
                default: ;
            endcase
        end
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.rx_busy    = rx_busy_q;

endmodule
